// File: rtl/gmii_phy_rx_gen.sv
// PHY-side GMII/MII receive-stream generator: frames an AXI-stream payload with preamble, SFD,
// CRC-32 FCS and inter-frame gap, in 1G byte mode or 10/100 nibble mode.
module gmii_phy_rx_gen #(
  parameter int unsigned IFG_MIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  input  logic       clk_enable,
  input  logic       mii_select,
  input  logic [7:0] ifg_delay,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       error_underflow
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StPayload, StFcs, StUnderflow, StIfg
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        mii_q, mii_d;
  logic        phase_q;
  logic [3:0]  hi_q;
  logic [7:0]  rxd_q;
  logic        dv_q, er_q, uf_q, tready_q, rdy_pend_q;

  logic [7:0]  byte_d, ifg_len;
  logic        dv_d, er_d, uf_d, ready_d, nib;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign ifg_len = (ifg_delay < 8'(IFG_MIN)) ? 8'(IFG_MIN) : ifg_delay;

  // One call of this block produces one byte time; nibble mode splits it over two cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    mii_d   = mii_q;
    byte_d  = 8'h00;
    dv_d    = 1'b0;
    er_d    = 1'b0;
    uf_d    = 1'b0;
    ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid) begin
          mii_d   = mii_select;
          byte_d  = 8'h55;
          dv_d    = 1'b1;
          cnt_d   = 8'd1;
          state_d = StPreamble;
        end
      end
      StPreamble: begin
        dv_d = 1'b1;
        if (cnt_q == 8'd7) begin
          byte_d  = 8'hD5;
          ready_d = 1'b1;
          state_d = StPayload;
        end else begin
          byte_d = 8'h55;
          cnt_d  = cnt_q + 8'd1;
        end
      end
      StPayload: begin
        dv_d = 1'b1;
        if (s_axis_tvalid) begin
          byte_d = s_axis_tdata;
          crc_d  = crc_byte(crc_q, s_axis_tdata);
          if (s_axis_tlast) begin
            er_d    = s_axis_tuser;
            cnt_d   = 8'd0;
            state_d = StFcs;
          end else begin
            ready_d = 1'b1;
          end
        end else begin
          er_d    = 1'b1;
          uf_d    = 1'b1;
          ready_d = 1'b1;
          state_d = StUnderflow;
        end
      end
      StFcs: begin
        dv_d   = 1'b1;
        byte_d = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == 8'd3) begin
          cnt_d   = 8'd0;
          state_d = StIfg;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StUnderflow: begin
        ready_d = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          ready_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = StIfg;
        end
      end
      StIfg: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d >= ifg_len) begin
          crc_d   = 32'hFFFF_FFFF;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Idle polling stays single-cycle so tvalid is seen on every enabled cycle.
  assign nib = mii_d && !((state_q == StIdle) && (state_d == StIdle));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      crc_q      <= 32'hFFFF_FFFF;
      mii_q      <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= 4'h0;
      rxd_q      <= 8'h00;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      uf_q       <= 1'b0;
      tready_q   <= 1'b0;
      rdy_pend_q <= 1'b0;
    end else begin
      uf_q <= 1'b0;
      if (clk_enable) begin
        if (!phase_q) begin
          state_q    <= state_d;
          cnt_q      <= cnt_d;
          crc_q      <= crc_d;
          mii_q      <= mii_d;
          dv_q       <= dv_d;
          er_q       <= er_d;
          uf_q       <= uf_d;
          rdy_pend_q <= ready_d;
          if (nib) begin
            rxd_q    <= {4'h0, byte_d[3:0]};
            hi_q     <= byte_d[7:4];
            phase_q  <= 1'b1;
            tready_q <= 1'b0;
          end else begin
            rxd_q    <= byte_d;
            tready_q <= ready_d;
          end
        end else begin
          rxd_q    <= {4'h0, hi_q};
          phase_q  <= 1'b0;
          tready_q <= rdy_pend_q;
        end
      end
    end
  end

  // Gated so no handshake can complete on a disabled cycle.
  assign s_axis_tready   = tready_q & clk_enable;
  assign gmii_rxd        = rxd_q;
  assign gmii_rx_dv      = dv_q;
  assign gmii_rx_er      = er_q;
  assign error_underflow = uf_q;

endmodule

// File: tb/tb_gmii_phy_rx_gen.sv
// Self-checking bench for gmii_phy_rx_gen: table of frames plus hand-written corner sequences.
module tb_gmii_phy_rx_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic       clk_enable, mii_select;
  logic [7:0] ifg_delay;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, error_underflow;

  gmii_phy_rx_gen #(.IFG_MIN(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .clk_enable(clk_enable), .mii_select(mii_select), .ifg_delay(ifg_delay),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .error_underflow(error_underflow)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] data; logic last; logic user; int gap; } beat_t;
  typedef struct { bit mii; bit toggle; bit user; logic [31:0] fcs; } vec_t;

  beat_t      tx_q[$];
  logic [8:0] cap_q[$];  // {er, rxd} per enabled output cycle with dv high
  logic [8:0] exp_q[$];
  int         runs_q[$];
  int         gaps_q[$];
  int         checks = 0, errors = 0;
  int         uf_cnt, first_dv, first_rdy, rdy_bad = 0;
  bit         uf_ok;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t d;
    for (int i = 0; i < s.len(); i++) d.push_back(s[i]);
    return d;
  endfunction

  function automatic logic [31:0] crc32(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c ^= {24'h0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void push_frame(input bq_t d, input bit user, input int gap_idx,
                                     input int gap_len);
    beat_t b;
    foreach (d[i]) begin
      b.data = d[i];
      b.last = (i == d.size() - 1);
      b.user = b.last && user;
      b.gap  = (i == gap_idx) ? gap_len : 0;
      tx_q.push_back(b);
    end
  endfunction

  function automatic void build_exp(input bq_t d, input bit mii, input bit user,
                                    input logic [31:0] fcs);
    logic [7:0] by[$];
    logic       er[$];
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin by.push_back(8'h55); er.push_back(1'b0); end
    by.push_back(8'hD5); er.push_back(1'b0);
    foreach (d[i]) begin by.push_back(d[i]); er.push_back(user && (i == d.size() - 1)); end
    for (int k = 0; k < 4; k++) begin by.push_back(fcs[8*k +: 8]); er.push_back(1'b0); end
    foreach (by[i]) begin
      if (mii) begin
        exp_q.push_back({er[i], 4'h0, by[i][3:0]});
        exp_q.push_back({er[i], 4'h0, by[i][7:4]});
      end else begin
        exp_q.push_back({er[i], by[i]});
      end
    end
  endfunction

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  // Drives tx_q through the handshake and captures the output stream until it goes quiet.
  task automatic run(input bit toggle, input int rst_at);
    int cyc, tail, run_len, low_len, gap_left;
    bit acc, en_last, seen_dv, rst_done, prev_er;
    cap_q.delete(); runs_q.delete(); gaps_q.delete();
    uf_cnt = 0; uf_ok = 1'b1; first_dv = -1; first_rdy = -1;
    cyc = 0; tail = 0; run_len = 0; low_len = 0; acc = 0; seen_dv = 0; rst_done = 0;
    prev_er = 0; en_last = clk_enable;
    gap_left = (tx_q.size() > 0) ? tx_q[0].gap : 0;
    while (tail < 40 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (en_last && gmii_rx_dv) cap_q.push_back({gmii_rx_er, gmii_rxd});
      if (gmii_rx_dv) begin
        if (low_len > 0) gaps_q.push_back(low_len);
        low_len = 0; run_len++; seen_dv = 1;
        if (first_dv < 0) first_dv = cyc;
      end else begin
        if (run_len > 0) runs_q.push_back(run_len);
        run_len = 0;
        if (seen_dv) low_len++;
      end
      if (error_underflow) begin
        uf_cnt++;
        if (!(gmii_rx_er && gmii_rx_dv && !prev_er)) uf_ok = 1'b0;
      end
      prev_er = gmii_rx_er;
      if (acc) begin
        void'(tx_q.pop_front());
        gap_left = (tx_q.size() > 0) ? tx_q[0].gap : 0;
      end
      if (rst_at >= 0 && !rst_done && cap_q.size() == rst_at) begin
        rst = 1'b1; s_axis_tvalid = 1'b0;
        @(negedge clk);
        cyc++;
        check("rst_mid_dv", gmii_rx_dv, 0);
        check("rst_mid_er", gmii_rx_er, 0);
        check("rst_mid_rxd", gmii_rxd, 0);
        check("rst_mid_tready", s_axis_tready, 0);
        rst = 1'b0; tx_q.delete(); rst_done = 1; acc = 0; en_last = clk_enable;
        run_len = 0; prev_er = 0;
        continue;
      end
      if (toggle) clk_enable = ~clk_enable;
      if (tx_q.size() > 0 && gap_left == 0) begin
        s_axis_tvalid = 1'b1; s_axis_tdata = tx_q[0].data;
        s_axis_tlast = tx_q[0].last; s_axis_tuser = tx_q[0].user;
      end else begin
        s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        if (gap_left > 0) gap_left--;
      end
      #1;
      if (s_axis_tready && !clk_enable) rdy_bad++;
      if (s_axis_tready && first_rdy < 0) first_rdy = cyc;
      acc = s_axis_tready && s_axis_tvalid;
      en_last = clk_enable;
      if (tx_q.size() == 0 && !gmii_rx_dv) tail++; else tail = 0;
    end
    if (run_len > 0) runs_q.push_back(run_len);
    if (cyc >= 4000) check("run_timeout", 1, 0);
    clk_enable = 1'b1; s_axis_tvalid = 1'b0;
  endtask

  vec_t  vecs[5];
  string vstr[5];
  bq_t   d;

  initial begin
    rst = 1'b1; clk_enable = 1'b1; mii_select = 1'b0; ifg_delay = 8'd12;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;

    vecs[0] = '{mii: 0, toggle: 0, user: 0, fcs: 32'hCBF43926}; vstr[0] = "123456789";
    vecs[1] = '{mii: 0, toggle: 1, user: 0, fcs: 32'hCBF43926}; vstr[1] = "123456789";
    vecs[2] = '{mii: 1, toggle: 0, user: 0, fcs: 32'hE8B7BE43}; vstr[2] = "a";
    vecs[3] = '{mii: 0, toggle: 0, user: 1, fcs: 32'h352441C2}; vstr[3] = "abc";
    vecs[4] = '{mii: 1, toggle: 0, user: 0, fcs: 32'hCBF43926}; vstr[4] = "123456789";

    repeat (3) @(negedge clk);
    check("reset_rxd", gmii_rxd, 0);
    check("reset_dv", gmii_rx_dv, 0);
    check("reset_er", gmii_rx_er, 0);
    check("reset_tready", s_axis_tready, 0);
    check("reset_underflow", error_underflow, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      d = str2q(vstr[v]);
      mii_select = vecs[v].mii;
      push_frame(d, vecs[v].user, -1, 0);
      run(vecs[v].toggle, -1);
      build_exp(d, vecs[v].mii, vecs[v].user, vecs[v].fcs);
      compare_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d_underflow", v), uf_cnt, 0);
      if (!vecs[v].toggle) begin
        check($sformatf("vec%0d_dv_runs", v), runs_q.size(), 1);
        if (runs_q.size() > 0)
          check($sformatf("vec%0d_dv_len", v), runs_q[0],
                (vecs[v].mii ? 2 : 1) * (d.size() + 12));
      end
    end
    check("tready_while_disabled", rdy_bad, 0);

    // Back-to-back frames: continuous dv, startup latency, inter-frame gap.
    mii_select = 1'b0;
    d = str2q("123456789");
    push_frame(d, 0, -1, 0);
    push_frame(d, 0, -1, 0);
    run(0, -1);
    check("b2b_runs", runs_q.size(), 2);
    if (runs_q.size() == 2) begin
      check("b2b_run0", runs_q[0], 21);
      check("b2b_run1", runs_q[1], 21);
    end
    check("b2b_gap_ge12", (gaps_q.size() > 0 && gaps_q[0] >= 12) ? 1 : 0, 1);
    check("b2b_tready_latency", first_rdy - first_dv, 7);
    check("b2b_cap_len", cap_q.size(), 42);

    // Nibble mode single byte 0xA5.
    mii_select = 1'b1;
    d.delete(); d.push_back(8'hA5);
    push_frame(d, 0, -1, 0);
    run(0, -1);
    build_exp(d, 1, 0, crc32(d));
    compare_stream("nib_a5");

    // Underflow after 3 bytes, then 2 more ending with tlast.
    mii_select = 1'b0;
    d = str2q("ABCDE");
    push_frame(d, 0, 3, 2);
    run(0, -1);
    check("uf_cap_len", cap_q.size(), 12);
    if (cap_q.size() >= 12) begin
      check("uf_byte2", cap_q[10], {1'b0, 8'h43});
      check("uf_err_byte", cap_q[11], 9'h100);
    end
    check("uf_pulses", uf_cnt, 1);
    check("uf_coincident", uf_ok, 1);
    check("uf_drained", tx_q.size(), 0);
    check("uf_dv_runs", runs_q.size(), 1);

    // Reset during payload byte 5, then a clean frame.
    d = str2q("0123456789");
    push_frame(d, 0, -1, 0);
    run(0, 13);
    d = str2q("123456789");
    push_frame(d, 0, -1, 0);
    run(0, -1);
    build_exp(d, 0, 0, 32'hCBF43926);
    compare_stream("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmii_phy_rx_gen.md
# gmii_phy_rx_gen

PHY-side GMII/MII receive-stream generator: turns an AXI-stream frame into the byte/nibble sequence a PHY presents to a MAC receiver. It adds preamble, SFD, CRC-32 FCS and inter-frame gap, and it injects errors on request. It drives the MAC's `gmii_rxd/rx_dv/rx_er` inputs in loopback and PHY-emulation builds, and covers both 1G byte mode and 10/100 nibble mode.

## Interface

Parameters:
- `IFG_MIN`, 1, minimum idle byte times between frames, applied when `ifg_delay` is smaller.

Ports:
- `clk`  in  1  sole clock, the GMII receive clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  8  frame payload byte, destination MAC first, FCS excluded.
- `s_axis_tvalid`  in  1  payload byte valid.
- `s_axis_tready`  out  1  byte accepted when high with `tvalid`.
- `s_axis_tlast`  in  1  last payload byte.
- `s_axis_tuser`  in  1  on the `tlast` beat: mark the frame bad.
- `clk_enable`  in  1  qualifies every cycle; all state holds when low.
- `mii_select`  in  1  1 = nibble mode (10/100), 0 = byte mode (1G); sampled only in IDLE.
- `ifg_delay`  in  8  idle byte times after each frame.
- `gmii_rxd`  out  8  receive data.
- `gmii_rx_dv`  out  1  receive data valid.
- `gmii_rx_er`  out  1  receive error.
- `error_underflow`  out  1  one-cycle pulse when `tvalid` drops mid-frame.

## Operation

- All outputs are registered.
- Reset: `gmii_rxd`=0, `gmii_rx_dv`=0, `gmii_rx_er`=0, `s_axis_tready`=0, `error_underflow`=0; state IDLE; CRC register = 0xFFFFFFFF.
- Byte time:
  - Byte mode: one enabled cycle.
  - Nibble mode: two enabled cycles. Low nibble is sent first on `gmii_rxd[3:0]`; `gmii_rxd[7:4]` is 0.
- State machine:
  - IDLE: `tvalid` on an enabled cycle latches `mii_select` and goes to PREAMBLE. No byte is consumed.
  - PREAMBLE: 7 byte times of 0x55, then 1 byte time of 0xD5 (SFD), all with dv=1. Goes to PAYLOAD.
  - PAYLOAD: `tready`=1 only on the enabled cycle that starts a byte time.
    - Accepted byte: drive it next byte time with dv=1 and fold it into the CRC.
    - `tlast` accepted: go to FCS.
    - `tuser`=1 on the `tlast` beat: `rx_er`=1 for that byte time.
  - FCS: 4 byte times of ~CRC, LSB byte first. Goes to IFG.
  - UNDERFLOW, entered when `tvalid`=0 while `tready`=1:
    - Drive one byte time of dv=1, `rx_er`=1, `rxd`=0.
    - Pulse `error_underflow`.
    - Then hold `tready`=1 and discard bytes until the `tlast` beat. No FCS is sent.
    - Goes to IFG.
  - IFG: dv=0, `rxd`=0 for max(`ifg_delay`, `IFG_MIN`) byte times. Goes to IDLE; the CRC reinitialises.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per byte over payload only.
- `clk_enable` low: outputs, counters and CRC hold. `tready`=0.
- `rst` mid-frame: outputs go to reset values the next cycle; the frame is truncated; the upstream frame remainder is not drained.

## Timing

- Byte mode with `clk_enable`=1, and `tvalid` first seen in IDLE in cycle 0:
  - Cycles 1–7: 0x55.
  - Cycle 8: 0xD5.
  - `tready` first high in cycle 8.
  - Payload byte accepted in cycle k appears in cycle k+1.
- FCS byte 0 follows the last payload byte with no gap.
- `dv` is continuous from the first preamble byte to the last FCS byte, unless an underflow occurs.
- Back-to-back frames: the next preamble starts no earlier than the byte time after IFG ends.
- `error_underflow` is high for exactly one `clk` cycle, coincident with the first `rx_er` cycle.

## Test plan

- Byte mode, `ifg_delay`=12, frame 0x31..0x39 with `tlast` on 0x39 -> output is 55×7, D5, 31..39, 26 39 F4 CB with dv high for 21 consecutive cycles; dv low for ≥12 cycles before the next frame.
- Nibble mode, single byte 0xA5 -> `rxd[3:0]` sequence is 5×15, D, 5, A, then the 8 FCS nibbles low-first; each nibble lasts 1 enabled cycle; `rxd[7:4]`=0.
- Byte mode, `clk_enable` toggling 1/0 -> same byte sequence as the first case; outputs change only after enabled cycles; `tready` is never high while `clk_enable`=0.
- `tvalid` dropped after 3 payload bytes, then 2 more bytes ending with `tlast` -> one byte time with `rx_er`=1, dv=1; `error_underflow` pulses once; no FCS; the 2 bytes are consumed; IFG follows.
- `tuser`=1 on the `tlast` beat -> `rx_er` high during that byte only; a correct FCS is still sent.
- `rst` asserted during payload byte 5 -> next cycle `dv`=`er`=`tready`=0 and `rxd`=0; a new frame after reset starts with a clean preamble and the correct FCS.
